basic_cpu_sequencer: RTL and testbench
======================================

Name: basic_cpu_sequencer

Overview:
- Control unit for the 16-bit basic-computer datapath: a timing counter plus decoder that sequences the AR, PC, DR, AC, IR and TR registers over the common bus.
- Drives the per-register clear/load/increment strobes, the bus select, memory read/write, the ALU op and the E-flag op.
- Covers fetch, decode and indirect addressing, plus execution of the memory-reference and register-reference instruction sets.
- Sits between the register file / memory and the top level.

Parameters:
- SC_W, 4, width of the timing counter (states T0..T(2^SC_W-1); instructions use T0..T6).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  leave IDLE and begin execution; ignored when not in IDLE.
- ir  in  16  IR register output: [15]=I, [14:12]=opcode D, [11:0]=address or register-reference bits.
- dr_zero  in  1  DR == 0.
- ac_zero  in  1  AC == 0.
- ac_msb  in  1  AC[15].
- e_flag  in  1  current E flip-flop.
- bus_sel  out  3  bus source: 0 none, 1 AR, 2 PC, 3 DR, 4 AC, 5 IR, 6 TR, 7 memory.
- ar_ctl, pc_ctl, dr_ctl, ac_ctl  out  3 each  {clr, ld, inr} strobes.
- ir_ld, tr_ld  out  1 each  load strobes.
- mem_rd, mem_wr  out  1 each  memory read (onto bus) / write of M[AR] <- bus.
- alu_op  out  3  0 none, 1 AND, 2 ADD, 3 pass DR, 4 CMA, 5 CIR, 6 CIL.
- e_ctl  out  2  0 hold, 1 clear, 2 complement, 3 load ALU carry/shift-out.
- t_cnt  out  SC_W  current timing count.
- halted  out  1  high in IDLE.

Behaviour:
- Reset (asynchronous, immediate):
  - state IDLE; t_cnt=0; halted=1.
  - Every strobe output is 0; bus_sel=0; alu_op=0; e_ctl=0.
  - The same applies when reset asserts mid-instruction.
- Output timing:
  - All strobe outputs are combinational from state, t_cnt, the internal I flip-flop and the ir/flag inputs.
  - Registers act on the next rising edge.
  - Memory reads are combinational: M[AR] is on the bus in the same cycle.
- States: IDLE, INIT, RUN.
  - IDLE & start -> INIT.
  - INIT (1 cycle): pc clr, ac clr, e_ctl=clear -> RUN with t_cnt=0.
  - RUN advances t_cnt by 1 each cycle; "SC<-0" means the next cycle is T0.
- Fetch / decode:
  - T0: bus_sel=2, ar ld.
  - T1: mem_rd, bus_sel=7, ir_ld, pc inr.
  - T2: bus_sel=5, ar ld (AR<-IR[11:0]); I flip-flop <- ir[15].
- T3:
  - D=7, I=0: register reference, then SC<-0.
  - D=7, I=1: I/O, treated as NOP, SC<-0.
  - D!=7, I=1: mem_rd, bus_sel=7, ar ld.
  - D!=7, I=0: no strobes.
- Memory reference (D0..D6), T4 onward:
  - AND: T4 mem_rd, bus 7, dr ld; T5 alu_op=AND, ac ld, SC<-0.
  - ADD: as AND but T5 alu_op=ADD, e_ctl=3.
  - LDA: as AND but T5 alu_op=3.
  - STA: T4 bus 4, mem_wr, SC<-0.
  - BUN: T4 bus 1, pc ld, SC<-0.
  - BSA: T4 bus 2, mem_wr, ar inr; T5 bus 1, pc ld, SC<-0.
  - ISZ: T4 DR<-M; T5 dr inr; T6 bus 3, mem_wr, pc inr if dr_zero, SC<-0.
- Register reference (T3, ir bits):
  - Exactly one bit is expected. If several are set, the highest-indexed set bit wins. No bits set is a NOP.
  - B11 CLA: ac clr.
  - B10 CLE: e_ctl=1.
  - B9 CMA: alu_op=4, ac ld.
  - B8 CME: e_ctl=2.
  - B7 CIR: alu_op=5, ac ld, e_ctl=3.
  - B6 CIL: alu_op=6, ac ld, e_ctl=3.
  - B5 INC: ac inr.
  - B4 SPA: pc inr if !ac_msb.
  - B3 SNA: pc inr if ac_msb.
  - B2 SZA: pc inr if ac_zero.
  - B1 SZE: pc inr if !e_flag.
  - B0 HLT: -> IDLE, halted=1 next cycle.
- Boundaries:
  - start during RUN/INIT is ignored.
  - t_cnt never exceeds 6. Any unreachable count forces SC<-0 with no strobes.
  - At most one of mem_rd / mem_wr is asserted in any cycle.

Decomposition:
- Shared package holds:
  - bus_sel codes (BUS_AR..BUS_MEM);
  - alu_op codes;
  - e_ctl codes;
  - opcode constants (OP_AND..OP_ISZ, OP_REG=7);
  - register-reference bit indices;
  - the state enum.
- One sub-module: seq_counter, the SC_W-bit timing counter with clr/inr strobes and async active-low reset, exporting t_cnt.

Test Plan:
- Reset, then start: halted=1 with all outputs 0; start -> INIT (pc_ctl=100, ac_ctl=100, e_ctl=1); T0 shows bus_sel=2, ar_ctl=010; T1 shows mem_rd=1, bus_sel=7, ir_ld=1, pc_ctl=001.
- ir=16'h7800 (CLA): T3 ac_ctl=100; next cycle t_cnt=0.
- ir=16'h1005 (ADD direct): T2 bus_sel=5, ar ld; T3 no strobes; T4 mem_rd, bus 7, dr ld; T5 alu_op=2, ac ld, e_ctl=3; T0 follows.
- ir=16'hA010 (LDA indirect): T3 mem_rd, bus 7, ar ld; T4 dr ld; T5 alu_op=3, ac ld.
- ir=16'h6020 (ISZ): with dr_zero=1 at T6, bus_sel=3, mem_wr=1, pc_ctl=001; repeated with dr_zero=0, pc_ctl=000.
- ir=16'h7001 (HLT): halted=1 and start re-enters INIT. rst_n low during BSA T4 zeroes all outputs before the next edge, and halted=1.

Source files
------------

// File: rtl/basic_cpu_sequencer_pkg.sv
// Shared encodings for the basic-computer control unit: bus sources, ALU and
// E-flag operations, opcodes, register-reference bit positions and FSM states.
package basic_cpu_sequencer_pkg;

  // Common bus source select
  localparam logic [2:0] BUS_NONE = 3'd0;
  localparam logic [2:0] BUS_AR   = 3'd1;
  localparam logic [2:0] BUS_PC   = 3'd2;
  localparam logic [2:0] BUS_DR   = 3'd3;
  localparam logic [2:0] BUS_AC   = 3'd4;
  localparam logic [2:0] BUS_IR   = 3'd5;
  localparam logic [2:0] BUS_TR   = 3'd6;
  localparam logic [2:0] BUS_MEM  = 3'd7;

  // ALU operation select
  localparam logic [2:0] ALU_NONE = 3'd0;
  localparam logic [2:0] ALU_AND  = 3'd1;
  localparam logic [2:0] ALU_ADD  = 3'd2;
  localparam logic [2:0] ALU_DR   = 3'd3;
  localparam logic [2:0] ALU_CMA  = 3'd4;
  localparam logic [2:0] ALU_CIR  = 3'd5;
  localparam logic [2:0] ALU_CIL  = 3'd6;

  // E flip-flop operation
  localparam logic [1:0] E_HOLD = 2'd0;
  localparam logic [1:0] E_CLR  = 2'd1;
  localparam logic [1:0] E_CMP  = 2'd2;
  localparam logic [1:0] E_LD   = 2'd3;

  // Register strobe bundles, ordered {clr, ld, inr}
  localparam logic [2:0] CTL_NONE = 3'b000;
  localparam logic [2:0] CTL_CLR  = 3'b100;
  localparam logic [2:0] CTL_LD   = 3'b010;
  localparam logic [2:0] CTL_INR  = 3'b001;

  // Opcode field IR[14:12]
  localparam logic [2:0] OP_AND = 3'd0;
  localparam logic [2:0] OP_ADD = 3'd1;
  localparam logic [2:0] OP_LDA = 3'd2;
  localparam logic [2:0] OP_STA = 3'd3;
  localparam logic [2:0] OP_BUN = 3'd4;
  localparam logic [2:0] OP_BSA = 3'd5;
  localparam logic [2:0] OP_ISZ = 3'd6;
  localparam logic [2:0] OP_REG = 3'd7;

  // Register-reference bit positions in IR[11:0]
  localparam int RB_CLA = 11;
  localparam int RB_CLE = 10;
  localparam int RB_CMA = 9;
  localparam int RB_CME = 8;
  localparam int RB_CIR = 7;
  localparam int RB_CIL = 6;
  localparam int RB_INC = 5;
  localparam int RB_SPA = 4;
  localparam int RB_SNA = 3;
  localparam int RB_SZA = 2;
  localparam int RB_SZE = 1;
  localparam int RB_HLT = 0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_INIT = 2'd1,
    ST_RUN  = 2'd2
  } state_t;

endpackage

// File: rtl/basic_cpu_sequencer_seq_counter.sv
// Timing counter SC: clear has priority over increment.
module seq_counter #(
  parameter int SC_W = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            clr,
  input  logic            inr,
  output logic [SC_W-1:0] t_cnt
);

  // Count register, cleared asynchronously by reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   t_cnt <= '0;
    else if (clr) t_cnt <= '0;
    else if (inr) t_cnt <= t_cnt + 1'b1;
  end

endmodule

// File: rtl/basic_cpu_sequencer.sv
// Control unit for the 16-bit basic computer: IDLE/INIT/RUN FSM plus timing
// decoder producing the per-register strobes, bus select and ALU/E controls.
module basic_cpu_sequencer
  import basic_cpu_sequencer_pkg::*;
#(
  parameter int SC_W = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [15:0]     ir,
  input  logic            dr_zero,
  input  logic            ac_zero,
  input  logic            ac_msb,
  input  logic            e_flag,
  output logic [2:0]      bus_sel,
  output logic [2:0]      ar_ctl,
  output logic [2:0]      pc_ctl,
  output logic [2:0]      dr_ctl,
  output logic [2:0]      ac_ctl,
  output logic            ir_ld,
  output logic            tr_ld,
  output logic            mem_rd,
  output logic            mem_wr,
  output logic [2:0]      alu_op,
  output logic [1:0]      e_ctl,
  output logic [SC_W-1:0] t_cnt,
  output logic            halted
);

  state_t     state, next_state;
  logic       i_ff, i_ld;
  logic       sc_clr, sc_inr;
  logic [2:0] op;

  assign op     = ir[14:12];
  assign halted = (state == ST_IDLE);
  assign tr_ld  = 1'b0;

  seq_counter #(.SC_W(SC_W)) u_sc (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (sc_clr),
    .inr   (sc_inr),
    .t_cnt (t_cnt)
  );

  // FSM state and indirect-address flip-flop
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      i_ff  <= 1'b0;
    end else begin
      state <= next_state;
      if (i_ld) i_ff <= ir[15];
    end
  end

  // Timing decode: next state, counter control and all datapath strobes
  always_comb begin
    next_state = state;
    sc_clr     = 1'b0;
    sc_inr     = 1'b0;
    i_ld       = 1'b0;
    bus_sel    = BUS_NONE;
    ar_ctl     = CTL_NONE;
    pc_ctl     = CTL_NONE;
    dr_ctl     = CTL_NONE;
    ac_ctl     = CTL_NONE;
    ir_ld      = 1'b0;
    mem_rd     = 1'b0;
    mem_wr     = 1'b0;
    alu_op     = ALU_NONE;
    e_ctl      = E_HOLD;
    case (state)
      ST_IDLE: begin
        sc_clr = 1'b1;
        if (start) next_state = ST_INIT;
      end
      ST_INIT: begin
        pc_ctl     = CTL_CLR;
        ac_ctl     = CTL_CLR;
        e_ctl      = E_CLR;
        sc_clr     = 1'b1;
        next_state = ST_RUN;
      end
      ST_RUN: begin
        sc_inr = 1'b1;
        case (t_cnt)
          SC_W'(0): begin
            bus_sel = BUS_PC;
            ar_ctl  = CTL_LD;
          end
          SC_W'(1): begin
            mem_rd  = 1'b1;
            bus_sel = BUS_MEM;
            ir_ld   = 1'b1;
            pc_ctl  = CTL_INR;
          end
          SC_W'(2): begin
            bus_sel = BUS_IR;
            ar_ctl  = CTL_LD;
            i_ld    = 1'b1;
          end
          SC_W'(3): begin
            if (op == OP_REG) begin
              sc_clr = 1'b1;
              // I/O instructions (I=1) fall through as a NOP; among several
              // set bits the highest index wins.
              if (!i_ff) begin
                if      (ir[RB_CLA]) ac_ctl = CTL_CLR;
                else if (ir[RB_CLE]) e_ctl  = E_CLR;
                else if (ir[RB_CMA]) begin alu_op = ALU_CMA; ac_ctl = CTL_LD; end
                else if (ir[RB_CME]) e_ctl  = E_CMP;
                else if (ir[RB_CIR]) begin alu_op = ALU_CIR; ac_ctl = CTL_LD; e_ctl = E_LD; end
                else if (ir[RB_CIL]) begin alu_op = ALU_CIL; ac_ctl = CTL_LD; e_ctl = E_LD; end
                else if (ir[RB_INC]) ac_ctl = CTL_INR;
                else if (ir[RB_SPA]) pc_ctl = ac_msb  ? CTL_NONE : CTL_INR;
                else if (ir[RB_SNA]) pc_ctl = ac_msb  ? CTL_INR  : CTL_NONE;
                else if (ir[RB_SZA]) pc_ctl = ac_zero ? CTL_INR  : CTL_NONE;
                else if (ir[RB_SZE]) pc_ctl = e_flag  ? CTL_NONE : CTL_INR;
                else if (ir[RB_HLT]) next_state = ST_IDLE;
              end
            end else if (i_ff) begin
              mem_rd  = 1'b1;
              bus_sel = BUS_MEM;
              ar_ctl  = CTL_LD;
            end
          end
          SC_W'(4): begin
            case (op)
              OP_AND, OP_ADD, OP_LDA, OP_ISZ: begin
                mem_rd  = 1'b1;
                bus_sel = BUS_MEM;
                dr_ctl  = CTL_LD;
              end
              OP_STA: begin
                bus_sel = BUS_AC;
                mem_wr  = 1'b1;
                sc_clr  = 1'b1;
              end
              OP_BUN: begin
                bus_sel = BUS_AR;
                pc_ctl  = CTL_LD;
                sc_clr  = 1'b1;
              end
              OP_BSA: begin
                bus_sel = BUS_PC;
                mem_wr  = 1'b1;
                ar_ctl  = CTL_INR;
              end
              default: sc_clr = 1'b1;
            endcase
          end
          SC_W'(5): begin
            case (op)
              OP_AND: begin alu_op = ALU_AND; ac_ctl = CTL_LD; sc_clr = 1'b1; end
              OP_ADD: begin alu_op = ALU_ADD; ac_ctl = CTL_LD; e_ctl = E_LD; sc_clr = 1'b1; end
              OP_LDA: begin alu_op = ALU_DR;  ac_ctl = CTL_LD; sc_clr = 1'b1; end
              OP_BSA: begin bus_sel = BUS_AR; pc_ctl = CTL_LD; sc_clr = 1'b1; end
              OP_ISZ: dr_ctl = CTL_INR;
              default: sc_clr = 1'b1;
            endcase
          end
          SC_W'(6): begin
            sc_clr = 1'b1;
            if (op == OP_ISZ) begin
              bus_sel = BUS_DR;
              mem_wr  = 1'b1;
              pc_ctl  = dr_zero ? CTL_INR : CTL_NONE;
            end
          end
          default: sc_clr = 1'b1;
        endcase
      end
      default: begin
        next_state = ST_IDLE;
        sc_clr     = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_basic_cpu_sequencer.sv
// Self-checking bench for basic_cpu_sequencer: directed scenarios plus random
// instruction streams compared against a per-instruction micro-op list model.
module tb_basic_cpu_sequencer;

  typedef struct packed {
    logic [2:0] bus;
    logic [2:0] ar;
    logic [2:0] pc;
    logic [2:0] dr;
    logic [2:0] ac;
    logic       irl;
    logic       trl;
    logic       rd;
    logic       wr;
    logic [2:0] alu;
    logic [1:0] e;
    logic [3:0] t;
    logic       hlt;
  } ctl_t;

  logic        clk = 1'b0;
  logic        rst_n, start;
  logic [15:0] ir;
  logic        dr_zero, ac_zero, ac_msb, e_flag;
  logic [2:0]  bus_sel, ar_ctl, pc_ctl, dr_ctl, ac_ctl, alu_op;
  logic        ir_ld, tr_ld, mem_rd, mem_wr, halted;
  logic [1:0]  e_ctl;
  logic [3:0]  t_cnt;

  int   n_checks = 0;
  int   n_fail   = 0;
  ctl_t exp_q[$];
  bit   exp_halt;

  always #5 clk = ~clk;

  basic_cpu_sequencer #(.SC_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .ir(ir),
    .dr_zero(dr_zero), .ac_zero(ac_zero), .ac_msb(ac_msb), .e_flag(e_flag),
    .bus_sel(bus_sel), .ar_ctl(ar_ctl), .pc_ctl(pc_ctl), .dr_ctl(dr_ctl),
    .ac_ctl(ac_ctl), .ir_ld(ir_ld), .tr_ld(tr_ld), .mem_rd(mem_rd),
    .mem_wr(mem_wr), .alu_op(alu_op), .e_ctl(e_ctl), .t_cnt(t_cnt),
    .halted(halted)
  );

  function automatic ctl_t observed();
    ctl_t c;
    c.bus = bus_sel; c.ar = ar_ctl; c.pc = pc_ctl; c.dr = dr_ctl; c.ac = ac_ctl;
    c.irl = ir_ld; c.trl = tr_ld; c.rd = mem_rd; c.wr = mem_wr;
    c.alu = alu_op; c.e = e_ctl; c.t = t_cnt; c.hlt = halted;
    return c;
  endfunction

  function automatic ctl_t blank(input int t);
    ctl_t c = '0;
    c.t = t[3:0];
    return c;
  endfunction

  function automatic ctl_t idle_ctl();
    ctl_t c = '0;
    c.hlt = 1'b1;
    return c;
  endfunction

  // Expected micro-op sequence of one instruction, T0 to its last cycle
  task automatic build(input logic [15:0] w, input logic dz, az, am, ef);
    ctl_t c;
    int   b;
    logic [2:0] d;
    d = w[14:12];
    exp_q.delete();
    exp_halt = 1'b0;
    c = blank(0); c.bus = 2; c.ar = 3'b010; exp_q.push_back(c);
    c = blank(1); c.rd = 1; c.bus = 7; c.irl = 1; c.pc = 3'b001; exp_q.push_back(c);
    c = blank(2); c.bus = 5; c.ar = 3'b010; exp_q.push_back(c);
    c = blank(3);
    if (d == 3'd7) begin
      if (!w[15]) begin
        b = -1;
        for (int k = 11; k >= 0; k--) if (w[k] && b < 0) b = k;
        case (b)
          11: c.ac = 3'b100;
          10: c.e = 1;
          9:  begin c.alu = 4; c.ac = 3'b010; end
          8:  c.e = 2;
          7:  begin c.alu = 5; c.ac = 3'b010; c.e = 3; end
          6:  begin c.alu = 6; c.ac = 3'b010; c.e = 3; end
          5:  c.ac = 3'b001;
          4:  if (!am) c.pc = 3'b001;
          3:  if (am)  c.pc = 3'b001;
          2:  if (az)  c.pc = 3'b001;
          1:  if (!ef) c.pc = 3'b001;
          0:  exp_halt = 1'b1;
          default: ;
        endcase
      end
      exp_q.push_back(c);
      return;
    end
    if (w[15]) begin c.rd = 1; c.bus = 7; c.ar = 3'b010; end
    exp_q.push_back(c);
    case (d)
      3'd0, 3'd1, 3'd2: begin
        c = blank(4); c.rd = 1; c.bus = 7; c.dr = 3'b010; exp_q.push_back(c);
        c = blank(5); c.ac = 3'b010;
        c.alu = (d == 3'd0) ? 3'd1 : (d == 3'd1) ? 3'd2 : 3'd3;
        c.e   = (d == 3'd1) ? 2'd3 : 2'd0;
        exp_q.push_back(c);
      end
      3'd3: begin c = blank(4); c.bus = 4; c.wr = 1; exp_q.push_back(c); end
      3'd4: begin c = blank(4); c.bus = 1; c.pc = 3'b010; exp_q.push_back(c); end
      3'd5: begin
        c = blank(4); c.bus = 2; c.wr = 1; c.ar = 3'b001; exp_q.push_back(c);
        c = blank(5); c.bus = 1; c.pc = 3'b010; exp_q.push_back(c);
      end
      default: begin
        c = blank(4); c.rd = 1; c.bus = 7; c.dr = 3'b010; exp_q.push_back(c);
        c = blank(5); c.dr = 3'b001; exp_q.push_back(c);
        c = blank(6); c.bus = 3; c.wr = 1; c.pc = dz ? 3'b001 : 3'b000; exp_q.push_back(c);
      end
    endcase
  endtask

  // Runs one instruction starting at T0 and checks every cycle plus the exit
  task automatic run_instr(input string name, input logic [15:0] w,
                           input logic dz, az, am, ef);
    ctl_t o;
    ir = w; dr_zero = dz; ac_zero = az; ac_msb = am; e_flag = ef;
    build(w, dz, az, am, ef);
    foreach (exp_q[k]) begin
      o = observed();
      n_checks++;
      if (o !== exp_q[k]) begin
        n_fail++;
        $display("FAIL %s ir=%h T%0d: got %h expected %h", name, w, k, o, exp_q[k]);
      end
      n_checks++;
      if ((mem_rd && mem_wr) || t_cnt > 4'd6) begin
        n_fail++;
        $display("FAIL %s_excl ir=%h T%0d: rd=%b wr=%b t=%0d, required no rd&wr, t<=6",
                 name, w, k, mem_rd, mem_wr, t_cnt);
      end
      @(posedge clk); #1;
    end
    o = observed();
    n_checks++;
    if (exp_halt) begin
      if (o !== idle_ctl()) begin
        n_fail++;
        $display("FAIL %s_halt: got %h expected %h", name, o, idle_ctl());
      end
    end else if (t_cnt !== 4'd0 || halted !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_next_t0: got t=%0d halted=%b expected t=0 halted=0", name, t_cnt, halted);
    end
  endtask

  // From IDLE: pulse start, check the INIT cycle, land on T0 of RUN
  task automatic do_start(input string name);
    ctl_t o, e;
    start = 1'b1;
    @(posedge clk); #1;
    e = blank(0); e.pc = 3'b100; e.ac = 3'b100; e.e = 1;
    o = observed();
    n_checks++;
    if (o !== e) begin
      n_fail++;
      $display("FAIL %s_init: got %h expected %h", name, o, e);
    end
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic test_reset();
    ctl_t o;
    rst_n = 1'b0; start = 1'b0; ir = 16'h0000;
    dr_zero = 0; ac_zero = 0; ac_msb = 0; e_flag = 0;
    repeat (2) @(posedge clk);
    #1;
    o = observed();
    n_checks++;
    if (o !== idle_ctl()) begin
      n_fail++;
      $display("FAIL reset_state: got %h expected %h", o, idle_ctl());
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    o = observed();
    n_checks++;
    if (o !== idle_ctl()) begin
      n_fail++;
      $display("FAIL idle_after_reset: got %h expected %h", o, idle_ctl());
    end
    do_start("start");
  endtask

  task automatic test_directed();
    run_instr("cla", 16'h7800, 0, 0, 0, 0);
    run_instr("add_dir", 16'h1005, 0, 0, 0, 0);
    run_instr("lda_ind", 16'hA010, 0, 0, 0, 0);
    run_instr("isz_dz1", 16'h6020, 1, 0, 0, 0);
    run_instr("isz_dz0", 16'h6020, 0, 0, 0, 0);
    run_instr("multi_bits", 16'h7281, 0, 0, 0, 0);
    run_instr("reg_nop", 16'h7000, 0, 0, 0, 0);
    run_instr("io_nop", 16'hF001, 0, 0, 0, 0);
  endtask

  task automatic test_start_ignored();
    start = 1'b1;
    run_instr("sta_start_held", 16'h3044, 0, 0, 0, 0);
    run_instr("bsa_start_held", 16'hD100, 0, 0, 0, 0);
    start = 1'b0;
  endtask

  task automatic test_hlt();
    run_instr("hlt", 16'h7001, 0, 0, 0, 0);
    @(posedge clk); #1;
    n_checks++;
    if (halted !== 1'b1 || t_cnt !== 4'd0) begin
      n_fail++;
      $display("FAIL hlt_stays_idle: got halted=%b t=%0d expected halted=1 t=0", halted, t_cnt);
    end
    do_start("restart");
  endtask

  task automatic test_reset_mid();
    ctl_t o, e;
    ir = 16'h5123; dr_zero = 0; ac_zero = 0; ac_msb = 0; e_flag = 0;
    repeat (4) @(posedge clk);
    #1;
    e = blank(4); e.bus = 2; e.wr = 1; e.ar = 3'b001;
    o = observed();
    n_checks++;
    if (o !== e) begin
      n_fail++;
      $display("FAIL bsa_t4: got %h expected %h", o, e);
    end
    rst_n = 1'b0;
    #1;
    o = observed();
    n_checks++;
    if (o !== idle_ctl()) begin
      n_fail++;
      $display("FAIL reset_mid: got %h expected %h", o, idle_ctl());
    end
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
    do_start("restart_after_reset");
  endtask

  task automatic test_random();
    logic [15:0] w;
    logic [2:0]  d;
    for (int n = 0; n < 60; n++) begin
      d = 3'($urandom_range(0, 7));
      w = 16'($urandom);
      w[14:12] = d;
      if (d == 3'd7 && $urandom_range(0, 9) < 6) begin
        w[15] = 1'b0;
        w[11:0] = 12'(1 << $urandom_range(0, 11));
      end
      run_instr("random", w, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
      if (exp_halt) do_start("random_restart");
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_start_ignored();
    test_hlt();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
